// File: rtl/cam_frame_writer_pkg.sv
// -----------------------------------------------------------------------------
// cam_frame_writer_pkg
//   Shared definitions for the camera capture path and the CNN blocks behind it
//   (window, conv, output buffer): default frame geometry, derived sizes and
//   the capture FSM state encoding.
//   No ports; imported with "import cam_frame_writer_pkg::*;".
// -----------------------------------------------------------------------------
package cam_frame_writer_pkg;

  // Camera frame as stored in the frame RAM.
  localparam int unsigned CAM_WIDTH  = 480;
  localparam int unsigned CAM_HEIGHT = 272;
  localparam int unsigned CAM_ADDR_W = 17;
  localparam int unsigned CAM_PIXELS = CAM_WIDTH * CAM_HEIGHT;

  // Geometry seen by the window / conv / output-buffer blocks. The conv
  // kernel is applied without padding, so the feature map shrinks by K-1.
  localparam int unsigned WIN_K      = 3;
  localparam int unsigned CONV_OUT_W = CAM_WIDTH - WIN_K + 1;
  localparam int unsigned CONV_OUT_H = CAM_HEIGHT - WIN_K + 1;
  localparam int unsigned OBUF_DEPTH = CONV_OUT_W * CONV_OUT_H;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_e;

endpackage

// File: rtl/cam_frame_writer_byte_pair.sv
// -----------------------------------------------------------------------------
// cam_byte_pair
//   Assembles two consecutive camera bytes into one RGB565 pixel. Holds the
//   byte phase and the first byte of the pair.
//   Ports:
//     i_clk, i_rst    clock, synchronous active-high reset
//     i_clear         drop phase and held byte (line end / frame start)
//     i_sample        a byte of the active line is present on i_byte
//     i_byte          camera byte
//     o_pix_vld       combinational: this sample completes a pixel
//     o_pix_data      combinational: assembled pixel, valid with o_pix_vld
//     o_phase         1 while a first byte is held (odd byte count so far)
// -----------------------------------------------------------------------------
module cam_byte_pair
  import cam_frame_writer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_sample,
  input  logic [7:0]  i_byte,
  output logic        o_pix_vld,
  output logic [15:0] o_pix_data,
  output logic        o_phase
);

  logic       r_phase;
  logic [7:0] r_first;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_phase <= 1'b0;
      r_first <= 8'h00;
    end else if (i_sample) begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_first <= i_byte;
      end
    end
  end

  assign o_pix_vld  = i_sample && r_phase;
  assign o_pix_data = MSB_FIRST ? {r_first, i_byte} : {i_byte, r_first};
  assign o_phase    = r_phase;

endmodule

// File: rtl/cam_frame_writer.sv
// -----------------------------------------------------------------------------
// cam_frame_writer
//   Captures one camera frame (8-bit bus, two bytes per RGB565 pixel) into a
//   frame RAM at address row*WIDTH+col. Capture starts only on a fresh
//   vsync high->low, so a frame already running at enable is skipped.
//   Ports:
//     iClk, iRst       clock, synchronous active-high reset
//     iCapEn           capture enable (level)
//     iPixEn           byte strobe; iVsync/iHref/iData sampled only when high
//     iVsync, iHref    frame blanking / line valid
//     iData            camera byte
//     oWrEn/oWrAddr/oWrData  registered frame-RAM write, one cycle per pixel
//     oFrameDone       one-cycle pulse at frame end
//     oBusy            high outside IDLE
//     oLineErr         sticky line-format error
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | capture off, waiting for iCapEn on a strobed sample
//   ST_WAIT_VS | armed, waiting for vsync high->low to start a frame
//   ST_ACTIVE  | capturing lines until vsync rises
//   ST_DONE    | single cycle, pulses oFrameDone, re-arms or idles
// -----------------------------------------------------------------------------
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int unsigned WIDTH     = CAM_WIDTH,
  parameter int unsigned HEIGHT    = CAM_HEIGHT,
  parameter int unsigned ADDR_W    = CAM_ADDR_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCapEn,
  input  logic              iPixEn,
  input  logic              iVsync,
  input  logic              iHref,
  input  logic [7:0]        iData,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [15:0]       oWrData,
  output logic              oFrameDone,
  output logic              oBusy,
  output logic              oLineErr
);

  localparam int unsigned COL_W = $clog2(WIDTH + 1);
  localparam int unsigned ROW_W = $clog2(HEIGHT + 1);
  localparam logic [COL_W-1:0]  COL_END  = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0]  ROW_END  = ROW_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  cam_state_e r_state;
  cam_state_e w_state_nxt;

  logic              r_vs_q;
  logic              r_href_q;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_line_err;

  logic        w_vs_rise;
  logic        w_vs_fall;
  logic        w_start;
  logic        w_act_smp;
  logic        w_byte_smp;
  logic        w_line_end;
  logic        w_col_ok;
  logic        w_row_ok;
  logic        w_pix_vld;
  logic [15:0] w_pix_data;
  logic        w_phase;
  logic        w_arm;

  // Edges are taken between consecutive strobed samples, not clock cycles.
  assign w_vs_rise = iPixEn &&  iVsync && !r_vs_q;
  assign w_vs_fall = iPixEn && !iVsync &&  r_vs_q;
  assign w_start   = (r_state == ST_WAIT_VS) && w_vs_fall;
  assign w_arm     = (r_state == ST_IDLE) && (w_state_nxt == ST_WAIT_VS);

  // The vsync-rise sample ends the frame; it carries no line data.
  assign w_act_smp  = (r_state == ST_ACTIVE) && iPixEn && !iVsync;
  assign w_byte_smp = w_act_smp && iHref;
  assign w_line_end = w_act_smp && !iHref && r_href_q;

  assign w_col_ok = (r_col < COL_END);
  assign w_row_ok = (r_row < ROW_END);

  cam_byte_pair #(
    .MSB_FIRST (MSB_FIRST)
  ) u_pair (
    .i_clk      (iClk),
    .i_rst      (iRst),
    .i_clear    (w_start || w_line_end),
    .i_sample   (w_byte_smp),
    .i_byte     (iData),
    .o_pix_vld  (w_pix_vld),
    .o_pix_data (w_pix_data),
    .o_phase    (w_phase)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    oBusy       = 1'b0;
    oFrameDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iPixEn && iCapEn) begin
          w_state_nxt = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        oBusy = 1'b1;
        if (w_vs_fall) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // iCapEn is deliberately ignored here so a started frame completes.
        oBusy = 1'b1;
        if (w_vs_rise) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        oBusy       = 1'b1;
        oFrameDone  = 1'b1;
        w_state_nxt = iCapEn ? ST_WAIT_VS : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_vs_q <= 1'b0;
    end else if (iPixEn) begin
      r_vs_q <= iVsync;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || w_start) begin
      r_href_q <= 1'b0;
    end else if (w_act_smp) begin
      r_href_q <= iHref;
    end
  end

  // Row/row_base saturate at HEIGHT so row_base never runs past the frame;
  // col saturates at WIDTH so surplus pixels are flagged without wrapping.
  always_ff @(posedge iClk) begin
    if (iRst || w_start) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (w_line_end) begin
      r_col <= '0;
      if (w_row_ok) begin
        r_row      <= r_row + ROW_W'(1);
        r_row_base <= r_row_base + ROW_STEP;
      end
    end else if (w_pix_vld && w_col_ok) begin
      r_col <= r_col + COL_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 16'h0000;
    end else begin
      r_wr_en <= 1'b0;
      if (w_pix_vld && w_col_ok && w_row_ok) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_row_base + ADDR_W'(r_col);
        r_wr_data <= w_pix_data;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || w_arm) begin
      r_line_err <= 1'b0;
    end else if ((w_pix_vld && !w_col_ok) ||
                 (w_line_end && (w_phase || w_col_ok))) begin
      r_line_err <= 1'b1;
    end
  end

  assign oWrEn    = r_wr_en;
  assign oWrAddr  = r_wr_addr;
  assign oWrData  = r_wr_data;
  assign oLineErr = r_line_err;

endmodule

// File: tb/tb_cam_frame_writer.sv
module tb_cam_frame_writer;

  localparam int W  = 16;
  localparam int H  = 10;
  localparam int AW = 8;

  logic iClk   = 1'b0;
  logic iRst   = 1'b1;
  logic iCapEn = 1'b0;
  logic iPixEn = 1'b0;
  logic iVsync = 1'b0;
  logic iHref  = 1'b0;
  logic [7:0] iData = 8'h00;

  logic          oWrEn, oWrEn_l;
  logic [AW-1:0] oWrAddr, oWrAddr_l;
  logic [15:0]   oWrData, oWrData_l;
  logic          oFrameDone, oFrameDone_l;
  logic          oBusy, oBusy_l;
  logic          oLineErr, oLineErr_l;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 iClk = ~iClk;

  cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .MSB_FIRST(1'b1)) dut (
    .iClk(iClk), .iRst(iRst), .iCapEn(iCapEn), .iPixEn(iPixEn), .iVsync(iVsync),
    .iHref(iHref), .iData(iData), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oFrameDone(oFrameDone), .oBusy(oBusy), .oLineErr(oLineErr));

  cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .MSB_FIRST(1'b0)) dut_lsb (
    .iClk(iClk), .iRst(iRst), .iCapEn(iCapEn), .iPixEn(iPixEn), .iVsync(iVsync),
    .iHref(iHref), .iData(iData), .oWrEn(oWrEn_l), .oWrAddr(oWrAddr_l), .oWrData(oWrData_l),
    .oFrameDone(oFrameDone_l), .oBusy(oBusy_l), .oLineErr(oLineErr_l));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: follows the capture rules sample by sample, keeps the
  // bytes of the current line in a queue and derives pixels from byte pairs.
  typedef enum int {M_OFF, M_ARMED, M_CAPT, M_END} mmode_e;
  mmode_e     m_mode = M_OFF;
  logic       m_prev_vs = 1'b0;
  logic       m_prev_href = 1'b0;
  int         m_line = 0;
  logic [7:0] m_bytes[$];
  logic       m_err = 1'b0;
  int         c;
  logic       exp_we = 1'b0;
  int         exp_addr = 0;
  logic [15:0] exp_dm = 16'h0, exp_dl = 16'h0;

  always @(posedge iClk) begin
    exp_we = 1'b0;
    if (iRst) begin
      m_mode = M_OFF;
      m_prev_vs = 1'b0;
      m_err = 1'b0;
      m_bytes.delete();
    end else begin
      case (m_mode)
        M_END: m_mode = iCapEn ? M_ARMED : M_OFF;
        M_OFF: if (iPixEn && iCapEn) begin
          m_mode = M_ARMED;
          m_err = 1'b0;
        end
        M_ARMED: if (iPixEn && !iVsync && m_prev_vs) begin
          m_mode = M_CAPT;
          m_line = 0;
          m_bytes.delete();
          m_prev_href = 1'b0;
        end
        M_CAPT: if (iPixEn) begin
          if (iVsync) begin
            m_mode = M_END;
          end else if (iHref) begin
            m_bytes.push_back(iData);
            if (m_bytes.size() % 2 == 0) begin
              c = m_bytes.size() / 2 - 1;
              if (c >= W) m_err = 1'b1;
              else if (m_line < H) begin
                exp_we   = 1'b1;
                exp_addr = m_line * W + c;
                exp_dm   = {m_bytes[2*c], m_bytes[2*c+1]};
                exp_dl   = {m_bytes[2*c+1], m_bytes[2*c]};
              end
            end
          end else if (m_prev_href) begin
            if ((m_bytes.size() % 2 != 0) || (m_bytes.size() / 2 < W)) m_err = 1'b1;
            m_line++;
            m_bytes.delete();
          end
          m_prev_href = iHref;
        end
        default: m_mode = M_OFF;
      endcase
      if (iPixEn) m_prev_vs = iVsync;
    end
  end

  int wr_addr_q[$];
  int fd_cnt = 0;

  always @(negedge iClk) begin
    if (chk_on) begin
      chk("wr_en", oWrEn, exp_we);
      chk("wr_en_lsb", oWrEn_l, exp_we);
      if (exp_we) begin
        chk("wr_addr", oWrAddr, exp_addr);
        chk("wr_addr_lsb", oWrAddr_l, exp_addr);
        chk("wr_data", oWrData, exp_dm);
        chk("wr_data_lsb", oWrData_l, exp_dl);
      end
      chk("busy", oBusy, m_mode != M_OFF);
      chk("busy_lsb", oBusy_l, m_mode != M_OFF);
      chk("frame_done", oFrameDone, m_mode == M_END);
      chk("frame_done_lsb", oFrameDone_l, m_mode == M_END);
      chk("line_err", oLineErr, m_err);
      chk("line_err_lsb", oLineErr_l, m_err);
      if (oWrEn === 1'b1) wr_addr_q.push_back(int'(oWrAddr));
      if (oFrameDone === 1'b1) fd_cnt++;
    end
  end

  task automatic step(input logic pe, input logic vs, input logic href, input logic [7:0] d);
    iPixEn = pe; iVsync = vs; iHref = href; iData = d;
    @(posedge iClk); #1;
  endtask

  task automatic vsync_pulse();
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Pixel p of the line carries value base+p+seed, high byte on the bus first.
  task automatic send_line(input int nbytes, input int base, input int seed);
    for (int k = 0; k < nbytes; k++) begin
      logic [15:0] v;
      v = 16'(base + k / 2 + seed);
      step(1'b1, 1'b0, 1'b1, (k % 2 == 0) ? v[15:8] : v[7:0]);
    end
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int f0;
    // Reset
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk_on = 1'b1;
    chk("rst_wr_en", oWrEn, 0);
    chk("rst_wr_addr", oWrAddr, 0);
    chk("rst_wr_data", oWrData, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oFrameDone, 0);
    chk("rst_err", oLineErr, 0);
    iRst = 1'b0;

    // Full frame, pixel = address; enable dropped late in the frame
    iCapEn = 1'b1;
    wr_addr_q.delete();
    f0 = fd_cnt;
    vsync_pulse();
    for (int r = 0; r < H; r++) begin
      send_line(2 * W, r * W, 0);
      if (r == H - 3) iCapEn = 1'b0;
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("full_writes", wr_addr_q.size(), W * H);
    chk("full_first_addr", wr_addr_q[0], 0);
    chk("full_last_addr", wr_addr_q[$], W * H - 1);
    chk("full_last_data", oWrData, W * H - 1);
    chk("full_done_cnt", fd_cnt - f0, 1);
    chk("full_err", oLineErr, 0);
    chk("full_idle_after", oBusy, 0);

    // Enable raised mid-frame: that frame is skipped, the next one captured
    wr_addr_q.delete();
    vsync_pulse();
    send_line(2 * W, 0, 7);
    for (int k = 0; k < 2 * W; k++) begin
      if (k == 10) iCapEn = 1'b1;
      step(1'b1, 1'b0, 1'b1, 8'(k + 1));
    end
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int r = 2; r < H; r++) send_line(2 * W, r * W, 7);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("midframe_writes", wr_addr_q.size(), 0);
    chk("midframe_armed", oBusy, 1);
    f0 = fd_cnt;
    vsync_pulse();
    for (int r = 0; r < H; r++) send_line(2 * W, r * W, 3);
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("next_frame_writes", wr_addr_q.size(), W * H);
    chk("next_frame_first", wr_addr_q[0], 0);
    chk("next_frame_done", fd_cnt - f0, 1);

    // Long line then odd-byte line
    wr_addr_q.delete();
    chk("pre_long_err", oLineErr, 0);
    vsync_pulse();
    send_line(2 * (W + 1), 0, 256);
    chk("long_line_err", oLineErr, 1);
    send_line(2 * W + 1, W, 512);
    for (int r = 2; r < H; r++) send_line(2 * W, r * W, 768);
    iCapEn = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("long_writes", wr_addr_q.size(), W * H);
    chk("line1_start", wr_addr_q[W], W);
    chk("line2_start", wr_addr_q[2 * W], 2 * W);
    chk("long_err_sticky", oLineErr, 1);
    iCapEn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("err_cleared_on_arm", oLineErr, 0);

    // Byte order with a gapped strobe
    vsync_pulse();
    step(1'b1, 1'b0, 1'b1, 8'hF8);
    chk("pair_first_no_wr", oWrEn, 0);
    step(1'b0, 1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("pair_wr_en", oWrEn, 1);
    chk("pair_msb_first", oWrData, 16'hF800);
    chk("pair_lsb_first", oWrData_l, 16'h00F8);
    step(1'b0, 1'b0, 1'b1, 8'hAA);
    chk("pair_single_wr", oWrEn, 0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("short_line_err", oLineErr, 1);
    step(1'b1, 1'b1, 1'b0, 8'h00);

    // Reset after a few lines
    wr_addr_q.delete();
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(2 * W, r * W, 768);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1, 8'(k + 40));
    iRst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 8'h77);
    iRst = 1'b0;
    chk("rst_mid_wr_en", oWrEn, 0);
    chk("rst_mid_addr", oWrAddr, 0);
    chk("rst_mid_data", oWrData, 0);
    chk("rst_mid_busy", oBusy, 0);
    chk("rst_mid_err", oLineErr, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 8'(k + 50));
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int r = 4; r < 6; r++) send_line(2 * W, r * W, 768);
    chk("rst_no_writes", wr_addr_q.size(), 3 * W + 3);
    vsync_pulse();
    for (int r = 0; r < H; r++) send_line(2 * W, r * W, 1024);
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("rst_resume_writes", wr_addr_q.size(), 3 * W + 3 + W * H);
    chk("rst_resume_first", wr_addr_q[3 * W + 3], 0);

    // Tall frame: lines beyond HEIGHT write nothing
    wr_addr_q.delete();
    f0 = fd_cnt;
    vsync_pulse();
    for (int r = 0; r < H + 3; r++) send_line(2 * W, r * W, 2048);
    chk("tall_no_early_done", fd_cnt - f0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("tall_done_pulse", oFrameDone, 1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("tall_writes", wr_addr_q.size(), W * H);
    chk("tall_last_addr", wr_addr_q[$], W * H - 1);
    chk("tall_done_cnt", fd_cnt - f0, 1);

    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
